// File: rtl/mole_scheduler_if.sv
// rtl/mole_scheduler_if.sv - control, button and result signals of the mole scheduler
interface mole_scheduler_if #(
    parameter int NUM_MOLES = 4
);
    logic                 start;
    logic                 stop;
    logic [1:0]           level;
    logic                 tick_ms;
    logic [10:0]          random_value;
    logic [NUM_MOLES-1:0] hit_buttons;
    logic [NUM_MOLES-1:0] mole_onehot;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 done;
    logic                 busy;
    logic [7:0]           round_count;
    logic [7:0]           hit_count;

    modport master (
        output start, stop, level, tick_ms, random_value, hit_buttons,
        input  mole_onehot, hit_pulse, miss_pulse, done, busy, round_count, hit_count
    );

    modport slave (
        input  start, stop, level, tick_ms, random_value, hit_buttons,
        output mole_onehot, hit_pulse, miss_pulse, done, busy, round_count, hit_count
    );
endinterface

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole round sequencer: random delay, mole up-window, hit/miss scoring
module mole_scheduler #(
    parameter int NUM_MOLES  = 4,
    parameter int BASE_UP_MS = 1000,
    parameter int ROUNDS     = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    mole_scheduler_if.slave  bus
);
    localparam int LOG_N = $clog2(NUM_MOLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_UP     = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [1:0]       state;
    logic [10:0]      delay_cnt;
    logic [15:0]      up_cnt;
    logic [1:0]       lvl_q;
    logic [LOG_N-1:0] prev_pos;

    logic [LOG_N-1:0]     raw_pos;
    logic [LOG_N-1:0]     pos;
    logic [NUM_MOLES-1:0] pos_onehot;
    logic [15:0]          window;
    logic                 hit;
    logic                 expire;

    // Never raise the same mole twice in a row; power-of-two width makes +1 wrap.
    always_comb begin
        raw_pos    = bus.random_value[LOG_N-1:0];
        pos        = (raw_pos == prev_pos) ? raw_pos + LOG_N'(1) : raw_pos;
        pos_onehot = NUM_MOLES'(1) << pos;
        window     = 16'(BASE_UP_MS) >> lvl_q;
        hit        = |(bus.hit_buttons & bus.mole_onehot);
        expire     = bus.tick_ms && (up_cnt == 16'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            delay_cnt       <= '0;
            up_cnt          <= '0;
            lvl_q           <= '0;
            prev_pos        <= '0;
            bus.mole_onehot <= '0;
            bus.hit_pulse   <= 1'b0;
            bus.miss_pulse  <= 1'b0;
            bus.done        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.round_count <= '0;
            bus.hit_count   <= '0;
        end else begin
            bus.hit_pulse  <= 1'b0;
            bus.miss_pulse <= 1'b0;
            bus.done       <= 1'b0;
            // Abort beats any hit or expiry; scores are left for the host to read.
            if (state != S_IDLE && bus.stop) begin
                state           <= S_IDLE;
                bus.busy        <= 1'b0;
                bus.mole_onehot <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            state           <= S_DELAY;
                            bus.busy        <= 1'b1;
                            bus.round_count <= '0;
                            bus.hit_count   <= '0;
                            delay_cnt       <= bus.random_value;
                            lvl_q           <= bus.level;
                        end
                    end
                    S_DELAY: begin
                        if (delay_cnt == '0) begin
                            state           <= S_UP;
                            bus.mole_onehot <= pos_onehot;
                            prev_pos        <= pos;
                            up_cnt          <= window;
                        end else if (bus.tick_ms) begin
                            delay_cnt <= delay_cnt - 11'd1;
                        end
                    end
                    S_UP: begin
                        if (hit) begin
                            state           <= S_RESULT;
                            bus.mole_onehot <= '0;
                            bus.hit_pulse   <= 1'b1;
                            bus.round_count <= bus.round_count + 8'd1;
                            bus.hit_count   <= bus.hit_count + 8'd1;
                        end else if (expire) begin
                            state           <= S_RESULT;
                            bus.mole_onehot <= '0;
                            bus.miss_pulse  <= 1'b1;
                            bus.round_count <= bus.round_count + 8'd1;
                        end else if (bus.tick_ms) begin
                            up_cnt <= up_cnt - 16'd1;
                        end
                    end
                    default: begin
                        if (bus.round_count == 8'(ROUNDS)) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state     <= S_DELAY;
                            delay_cnt <= bus.random_value;
                            lvl_q     <= bus.level;
                        end
                    end
                endcase
            end
        end
    end
endmodule
